// File: rtl/coax_pkg.sv
// Shared definitions for the buffered coax transmitter.
// Frame state encoding and fixed frame-section lengths.
package coax_pkg;

  localparam int LQ_BITS  = 6;
  localparam int CV_BITS  = 3;
  localparam int END_BITS = 3;

  typedef enum logic [3:0] {
    IDLE,
    LQ1, LQ2, LQ3, LQ4, LQ5, LQ6,
    CV1, CV2, CV3,
    SYNC, DATA, PARITY,
    END1, END2, END3
  } state_t;

endpackage

// File: rtl/coax_fifo.sv
// Word buffer for the coax transmitter.
// Show-ahead read data; simultaneous write and read allowed when full.
module coax_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_wr;
  logic             do_rd;

  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr];

  // Storage array, written on accepted enqueue.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/coax_buffered_tx.sv
// Buffered coax frame transmitter.
// Buffer feeds a framing FSM; queued words extend the current frame.
module coax_buffered_tx
  import coax_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = 8,
  parameter int WORD_WIDTH     = 10,
  parameter int DEPTH          = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WORD_WIDTH-1:0] data,
  input  logic                  valid,
  output logic                  ready,
  output logic                  full,
  output logic                  empty,
  output logic                  active,
  output logic                  tx,
  output logic                  tx_delay,
  output logic                  tx_inverted
);

  localparam int CW = $clog2(CLOCKS_PER_BIT);
  localparam int DW = $clog2(WORD_WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLOCKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLOCKS_PER_BIT / 2);
  localparam logic [DW-1:0] BIT_LAST = DW'(WORD_WIDTH - 1);

  state_t                state;
  state_t                state_nx;
  logic [CW-1:0]         cnt;
  logic [DW-1:0]         bidx;
  logic [WORD_WIDTH-1:0] shreg;
  logic                  par;
  logic [1:0]            dly;
  logic [WORD_WIDTH-1:0] rd_data;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  strobe;
  logic                  first_half;
  logic                  pop;
  logic                  wr;
  logic                  b;

  assign strobe     = cnt == CNT_LAST;
  assign first_half = cnt < CNT_HALF;
  assign ready      = !fifo_full;
  assign full       = fifo_full;
  assign empty      = fifo_empty;
  assign wr         = valid && !fifo_full;
  assign pop        = strobe && (state == CV3 ||
                      (state == PARITY && !fifo_empty));
  assign b          = (state == PARITY) ? par : shreg[WORD_WIDTH-1];

  coax_fifo #(
    .WIDTH (WORD_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr),
    .wr_data (data),
    .rd_en   (pop),
    .rd_data (rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Frame state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Clock-in-bit and bit-in-word counters; held at zero while idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      bidx <= '0;
    end else begin
      if (state == IDLE || strobe) cnt <= '0;
      else                         cnt <= cnt + 1'b1;
      if (state != DATA) bidx <= '0;
      else if (strobe)   bidx <= bidx + 1'b1;
    end
  end

  // Word load on entry to SYNC, MSB-first shift during DATA.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg <= '0;
      par   <= 1'b0;
    end else if (pop) begin
      shreg <= rd_data;
      par   <= ~^rd_data;
    end else if (state == DATA && strobe) begin
      shreg <= shreg << 1;
    end
  end

  // Two-clock line delay, preset high between frames.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        dly <= 2'b11;
    else if (!active) dly <= 2'b11;
    else              dly <= {dly[0], tx};
  end

  // Next-state sequencing, advancing on bit boundaries.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:   if (!fifo_empty) state_nx = LQ1;
      LQ1:    if (strobe) state_nx = LQ2;
      LQ2:    if (strobe) state_nx = LQ3;
      LQ3:    if (strobe) state_nx = LQ4;
      LQ4:    if (strobe) state_nx = LQ5;
      LQ5:    if (strobe) state_nx = LQ6;
      LQ6:    if (strobe) state_nx = CV1;
      CV1:    if (strobe) state_nx = CV2;
      CV2:    if (strobe) state_nx = CV3;
      CV3:    if (strobe) state_nx = SYNC;
      SYNC:   if (strobe) state_nx = DATA;
      DATA:   if (strobe && bidx == BIT_LAST) state_nx = PARITY;
      PARITY: if (strobe) state_nx = fifo_empty ? END1 : SYNC;
      END1:   if (strobe) state_nx = END2;
      END2:   if (strobe) state_nx = END3;
      END3:   if (strobe) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Line encoding from state and half-bit phase.
  always_comb begin
    tx = 1'b0;
    unique case (state)
      LQ1, LQ2, LQ3, LQ4, LQ5, LQ6,
      CV2, SYNC:        tx = !first_half;
      CV3, END2, END3:  tx = 1'b1;
      DATA, PARITY:     tx = first_half ? ~b : b;
      END1:             tx = first_half;
      default:          tx = 1'b0;
    endcase
  end

  assign active      = state != IDLE && !(state == LQ1 && first_half);
  assign tx_inverted = active & ~tx;
  assign tx_delay    = active & dly[1];

endmodule

// File: tb/tb_coax_buffered_tx.sv
// Bench for coax_buffered_tx.
// Per-clock waveform capture compared with a frame-level model.
module tb_coax_buffered_tx;
  import coax_pkg::*;

  localparam int CPB   = 8;
  localparam int W     = 10;
  localparam int DEPTH = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         valid;
  logic [W-1:0] data;
  logic         ready, full, empty, active;
  logic         tx, tx_delay, tx_inverted;

  int n_tests = 0;
  int n_fail  = 0;

  bit rec_on = 1'b0;
  bit q_tx[$], q_act[$], q_dly[$], q_inv[$], q_wr[$];

  logic [W-1:0] mwords[$];
  bit           exp_tx[$];
  int           bad_i;

  coax_buffered_tx #(
    .CLOCKS_PER_BIT (CPB),
    .WORD_WIDTH     (W),
    .DEPTH          (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .data        (data),
    .valid       (valid),
    .ready       (ready),
    .full        (full),
    .empty       (empty),
    .active      (active),
    .tx          (tx),
    .tx_delay    (tx_delay),
    .tx_inverted (tx_inverted)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rec_on) begin
      q_tx.push_back(tx);
      q_act.push_back(active);
      q_dly.push_back(tx_delay);
      q_inv.push_back(tx_inverted);
      q_wr.push_back(valid && ready);
    end
  end

  // ---- frame model: half-bit levels per bit time ----
  task automatic bit_time(input bit h0, input bit h1);
    for (int c = 0; c < CPB; c++) exp_tx.push_back(c < CPB/2 ? h0 : h1);
  endtask

  task automatic build_model();
    bit p;
    exp_tx.delete();
    repeat (LQ_BITS) bit_time(1'b0, 1'b1);
    bit_time(1'b0, 1'b0);
    bit_time(1'b0, 1'b1);
    bit_time(1'b1, 1'b1);
    foreach (mwords[j]) begin
      bit_time(1'b0, 1'b1);
      for (int k = W-1; k >= 0; k--) bit_time(~mwords[j][k], mwords[j][k]);
      p = 1'b1 ^ (^mwords[j]);
      bit_time(~p, p);
    end
    bit_time(1'b1, 1'b0);
    bit_time(1'b1, 1'b1);
    bit_time(1'b1, 1'b1);
  endtask

  function automatic int frame_len();
    return (LQ_BITS + CV_BITS + END_BITS + mwords.size() * (W + 2)) * CPB;
  endfunction

  function automatic bit e_act(int i);
    return i >= CPB/2 && i < exp_tx.size();
  endfunction

  function automatic bit e_tx(int i);
    return i < exp_tx.size() ? exp_tx[i] : 1'b0;
  endfunction

  function automatic bit e_dly(int i);
    if (!e_act(i)) return 1'b0;
    if (i < CPB/2 + 2) return 1'b1;
    return exp_tx[i-2];
  endfunction

  function automatic bit e_inv(int i);
    return e_act(i) & ~e_tx(i);
  endfunction

  // ---- capture utilities ----
  function automatic int first_wr();
    foreach (q_wr[i]) if (q_wr[i]) return i;
    return -100;
  endfunction

  function automatic int first_act();
    foreach (q_act[i]) if (q_act[i]) return i;
    return -1;
  endfunction

  function automatic int count_act();
    int n = 0;
    foreach (q_act[i]) n += int'(q_act[i]);
    return n;
  endfunction

  function automatic int count_tx();
    int n = 0;
    foreach (q_tx[i]) n += int'(q_tx[i]);
    return n;
  endfunction

  function automatic int count_wr();
    int n = 0;
    foreach (q_wr[i]) n += int'(q_wr[i]);
    return n;
  endfunction

  function automatic int wave_errs(int st);
    int e = 0;
    int len = exp_tx.size() + CPB;
    bad_i = -1;
    if (st < 0 || q_tx.size() < st + len) return -1;
    for (int i = 0; i < len; i++) begin
      if (q_tx[st+i] !== e_tx(i) || q_act[st+i] !== e_act(i) ||
          q_dly[st+i] !== e_dly(i) || q_inv[st+i] !== e_inv(i)) begin
        if (bad_i < 0) bad_i = i;
        e++;
      end
    end
    return e;
  endfunction

  // ---- drivers ----
  task automatic start_rec();
    q_tx.delete(); q_act.delete(); q_dly.delete();
    q_inv.delete(); q_wr.delete();
    rec_on = 1'b1;
  endtask

  task automatic drain(input int n);
    repeat (n) @(posedge clk);
    #1;
    rec_on = 1'b0;
  endtask

  task automatic wr_word(input logic [W-1:0] d);
    valid = 1'b1;
    data  = d;
    @(posedge clk);
    #1;
    valid = 1'b0;
  endtask

  // ---- scenarios ----
  task automatic test_reset();
    reset = 1'b1;
    valid = 1'b0;
    data  = '0;
    #3;
    n_tests++;
    if ({tx, tx_inverted, tx_delay, active, empty, full, ready} !== 7'b0000101) begin
      n_fail++;
      $display("FAIL reset_early: outs=%b required 0000101",
               {tx, tx_inverted, tx_delay, active, empty, full, ready});
    end
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({tx, tx_inverted, tx_delay, active, empty, full, ready} !== 7'b0000101) begin
      n_fail++;
      $display("FAIL reset_held: outs=%b required 0000101",
               {tx, tx_inverted, tx_delay, active, empty, full, ready});
    end
    reset = 1'b0;
    start_rec();
    drain(20 * CPB);
    n_tests++;
    if (count_act() + count_tx() !== 0) begin
      n_fail++;
      $display("FAIL reset_quiet: %0d busy samples, required 0",
               count_act() + count_tx());
    end
  endtask

  task automatic test_single();
    int st, e;
    mwords = {10'h000};
    build_model();
    start_rec();
    wr_word(10'h000);
    drain(frame_len() + 4 * CPB);
    st = first_wr() + 2;
    n_tests++;
    if (first_act() !== st + CPB/2) begin
      n_fail++;
      $display("FAIL single_start: active at %0d, required %0d", first_act(), st + CPB/2);
    end
    n_tests++;
    e = wave_errs(st);
    if (e != 0) begin
      n_fail++;
      $display("FAIL single_wave: %0d bad samples (first %0d), required 0", e, bad_i);
    end
    n_tests++;
    if (count_act() !== 192 - CPB/2) begin
      n_fail++;
      $display("FAIL single_len: active %0d clocks, required %0d", count_act(), 192 - CPB/2);
    end
    n_tests++;
    if (empty !== 1'b1) begin
      n_fail++;
      $display("FAIL single_empty: empty=%b required 1", empty);
    end
  endtask

  task automatic test_two_words();
    int st, e;
    mwords = {10'h3FF, 10'h155};
    build_model();
    start_rec();
    wr_word(10'h3FF);
    wr_word(10'h155);
    drain(frame_len() + 4 * CPB);
    st = first_wr() + 2;
    n_tests++;
    e = wave_errs(st);
    if (e != 0) begin
      n_fail++;
      $display("FAIL two_wave: %0d bad samples (first %0d), required 0", e, bad_i);
    end
    n_tests++;
    if (count_act() !== 36 * CPB - CPB/2) begin
      n_fail++;
      $display("FAIL two_len: active %0d clocks, required %0d", count_act(), 36 * CPB - CPB/2);
    end
  endtask

  task automatic test_late_append();
    int st, e, k, wsamp, ps;
    logic [W-1:0] w1, w2;
    w1 = W'($urandom);
    w2 = W'($urandom);
    k  = $urandom_range(81, 160);
    start_rec();
    wr_word(w1);
    repeat (k) @(posedge clk);
    #1;
    wr_word(w2);
    st    = first_wr() + 2;
    wsamp = first_wr() + 1 + k;
    ps    = st + (LQ_BITS + CV_BITS + 1 + W) * CPB;
    mwords = {w1};
    if (wsamp <= ps + CPB - 2) mwords.push_back(w2);
    build_model();
    drain(frame_len() + 4 * CPB);
    n_tests++;
    e = wave_errs(st);
    if (e != 0) begin
      n_fail++;
      $display("FAIL late_wave: %0d bad samples (first %0d), required 0", e, bad_i);
    end
    n_tests++;
    if (count_act() !== frame_len() - CPB/2) begin
      n_fail++;
      $display("FAIL late_len: active %0d clocks, required %0d", count_act(), frame_len() - CPB/2);
    end
  endtask

  task automatic test_fill();
    int st, e;
    logic [W-1:0] w;
    mwords.delete();
    start_rec();
    for (int i = 0; i < DEPTH; i++) begin
      w = W'($urandom);
      mwords.push_back(w);
      wr_word(w);
    end
    n_tests++;
    if ({full, ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL fill_full: full,ready=%b required 10", {full, ready});
    end
    wr_word(W'($urandom));
    build_model();
    drain(frame_len() + 4 * CPB);
    n_tests++;
    if (count_wr() !== DEPTH) begin
      n_fail++;
      $display("FAIL fill_accept: %0d accepted, required %0d", count_wr(), DEPTH);
    end
    st = first_wr() + 2;
    n_tests++;
    e = wave_errs(st);
    if (e != 0) begin
      n_fail++;
      $display("FAIL fill_wave: %0d bad samples (first %0d), required 0", e, bad_i);
    end
  endtask

  task automatic test_reset_cv2();
    wr_word(W'($urandom));
    wr_word(W'($urandom));
    repeat ((LQ_BITS + 1) * CPB + CPB/2 + 1) @(posedge clk);
    #2;
    n_tests++;
    if ({tx, active} !== 2'b11) begin
      n_fail++;
      $display("FAIL cv2_pre: tx,active=%b required 11", {tx, active});
    end
    reset = 1'b1;
    #1;
    n_tests++;
    if ({tx, active, tx_delay, tx_inverted, empty, full, ready} !== 7'b0000101) begin
      n_fail++;
      $display("FAIL cv2_reset: outs=%b required 0000101",
               {tx, active, tx_delay, tx_inverted, empty, full, ready});
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    start_rec();
    drain(40 * CPB);
    n_tests++;
    if (count_act() + count_tx() !== 0) begin
      n_fail++;
      $display("FAIL cv2_quiet: %0d busy samples, required 0", count_act() + count_tx());
    end
  endtask

  task automatic test_random_frames();
    int st, e, n;
    logic [W-1:0] w;
    for (int f = 0; f < 3; f++) begin
      n = $urandom_range(1, 4);
      mwords.delete();
      start_rec();
      for (int i = 0; i < n; i++) begin
        w = W'($urandom);
        mwords.push_back(w);
        wr_word(w);
      end
      build_model();
      drain(frame_len() + 4 * CPB);
      st = first_wr() + 2;
      n_tests++;
      if (first_act() !== st + CPB/2) begin
        n_fail++;
        $display("FAIL rand%0d_start: active at %0d, required %0d", f, first_act(), st + CPB/2);
      end
      n_tests++;
      e = wave_errs(st);
      if (e != 0) begin
        n_fail++;
        $display("FAIL rand%0d_wave: %0d bad samples (first %0d), required 0", f, e, bad_i);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_two_words();
    test_late_append();
    test_fill();
    test_reset_cv2();
    test_random_frames();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
